pipe_i_decoder: RTL
===================

Name: pipe_i_decoder

Overview:
Registered, parametrised successor to the combinational instruction decoder. It sits between fetch and execute. Fetched {instr, pc} pairs are buffered in an input queue of depth QDEPTH. Each instruction is decoded into a valid/ready output register. An optional load-use interlock inserts bubbles, with a bubble counter and a synchronous flush for taken branches and jumps.

Parameters:
QDEPTH, 2, input queue entries (power of two, >=2)
PC_W, 32, program-counter width carried alongside each instruction
HAZARD_EN, 1, 1 = load-use interlock active; 0 = never stall
CNT_W, 16, width of the stall_cnt saturating counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  sync flush: discard queue and output register
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept (count<QDEPTH && !flush)
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
out_pc  out  PC_W  pc of decoded instruction
out_rs  out  5  instr[25:21]
out_rt  out  5  instr[20:16]
Af  out  4  ALU function
I  out  1  I-type
ALU_MUX_SEL  out  1  1 = second ALU operand from rt
Cad  out  5  GPR write address
GP_WE  out  1  GPR write enable
GP_MUX_SEL  out  2  0 alu, 1 memory, 2 shifter, 3 pc
Bf  out  4  branch-condition function
DM_WE  out  1  data-memory write
Shift_type  out  3  shifter op
PC_MUX_SEL  out  2  0 register, 1 branch, 2 jump, 3 sequential
stall_cnt  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty, out_valid=0, stall_cnt=0.
  - All decoded fields, out_pc, out_rs and out_rt are 0.
  - in_ready=1 after release.
- Decode fields (opc=instr[31:26], fun=instr[5:0], rt=[20:16], rd=[15:11]):
  - R = opc[5]==0 && opc[3:0]==0; J = opc[5:2]==0 && opc[1]; Itype = !(R||J).
  - jal: opc==3. jr: opc==0 && fun==8. jalr: opc==0 && fun==9. srl: opc==0 && fun==2.
  - load l: opc[5:3]==4. alu: (R && fun[5:4]==2) || (Itype && opc[5:3]==1).
  - Af = R ? fun[3:0] : {!opc[2]&&opc[1], opc[2:0]}. I = Itype. ALU_MUX_SEL = R.
  - Cad = jal ? 31 : (R ? rd : rt). GP_WE = alu||srl||l||jal||jalr.
  - GP_MUX_SEL = alu ? 0 : opc==0x23 ? 1 : srl ? 2 : 3.
  - Bf = {instr[28:26], instr[16]}. DM_WE = opc==0x2B. Shift_type = instr[2:0].
  - PC_MUX_SEL = (jr||jalr) ? 0 : branch ? 1 : (J||jal) ? 2 : 3.
  - branch: opc[5:3]==0 && ((opc[2:0]==1 && rt[4:1]==0) || opc[2:1]==2'b10 || (opc[2:1]==2'b11 && rt==0)). Uses the rt field, not fun.
- Queue:
  - FIFO with wrap-around pointers. Push when in_valid && in_ready.
  - Full: in_ready=0. No same-cycle pass-through when full, even if popping.
  - Empty: no issue.
- Issue/advance:
  - adv = !out_valid || out_ready.
  - Head issues when queue is non-empty, adv, and no hazard. The head pops and the output register loads the decoded head on the edge.
  - If adv with an empty queue or a hazard, out_valid becomes 0.
  - When !adv, the output register holds stable (no change while out_valid && !out_ready).
- Latency: an instruction accepted at edge N gives out_valid=1 after edge N+1 at the earliest (queue empty, adv true). Sustained throughput is 1 per cycle.
- Hazard (HAZARD_EN=1):
  - hazard = out_valid && out_is_load && out_Cad!=0 && (out_Cad==head_rs || out_Cad==head_rt).
  - On adv with hazard: one bubble (out_valid=0) and stall_cnt+1, saturating at all-ones. The head stays in the queue and issues next cycle.
  - HAZARD_EN=0: hazard is forced 0.
- Flush:
  - Next edge: queue empty, out_valid=0.
  - Flush has priority over push, pop and issue in the same cycle. in_ready=0 during flush.
  - stall_cnt is unaffected.
- Reset mid-operation: immediate clear, including queue contents. No partial bundle is ever presented.

Test Plan:
- Reset then push 0x00430820 (add $1,$2,$3), pc 0x100 -> out_valid 1 cycle later: Af=0, Cad=1, GP_WE=1, GP_MUX_SEL=0, ALU_MUX_SEL=1, PC_MUX_SEL=3, out_pc=0x100.
- Push lw 0x8C220004 then add 0x00220820 back-to-back, out_ready=1 -> lw out (GP_MUX_SEL=1, Cad=2); one bubble cycle; add issues; stall_cnt=1. Repeat with HAZARD_EN=0 -> no bubble, stall_cnt=0.
- Hold out_ready=0, push 3 instructions (QDEPTH=2) -> first in output reg, 2 queued, in_ready=0. Fields stay stable. Releasing out_ready drains in order, 1 per cycle.
- jal 0x0C000010 -> Cad=31, GP_WE=1, GP_MUX_SEL=3, PC_MUX_SEL=2. jr $31 0x03E00008 -> PC_MUX_SEL=0, GP_WE=0. beq 0x10220003 -> PC_MUX_SEL=1, Bf=4'b1000.
- flush asserted with full queue, valid output and in_valid=1 -> next cycle out_valid=0, queue empty, pushed word discarded, in_ready=1.
- Force 2^CNT_W+3 load-use pairs (CNT_W=4 variant) -> stall_cnt saturates at 15. Assert rst_n=0 mid-stream -> outputs and stall_cnt zero immediately.

Source files
------------

// File: rtl/pipe_i_decoder.sv
// Registered instruction decoder between fetch and execute: a small input FIFO
// feeding a valid/ready output register, with an optional load-use interlock.
`timescale 1ns/1ps

module pipe_i_decoder #(
  parameter int QDEPTH    = 2,
  parameter int PC_W      = 32,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [3:0]       Af,
  output logic             I,
  output logic             ALU_MUX_SEL,
  output logic [4:0]       Cad,
  output logic             GP_WE,
  output logic [1:0]       GP_MUX_SEL,
  output logic [3:0]       Bf,
  output logic             DM_WE,
  output logic [2:0]       Shift_type,
  output logic [1:0]       PC_MUX_SEL,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  localparam bit HZ_ON = (HAZARD_EN != 0);

  typedef struct packed {
    logic [3:0] af;
    logic       i;
    logic       alu_mux_sel;
    logic [4:0] cad;
    logic       gp_we;
    logic [1:0] gp_mux_sel;
    logic [3:0] bf;
    logic       dm_we;
    logic [2:0] shift_type;
    logic [1:0] pc_mux_sel;
    logic       is_load;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    logic [5:0] opc, fun;
    logic [4:0] rt, rd;
    logic       r_t, j_t, i_t, jal, jr, jalr, srl, ld, alu, br;
    dec_t       d;
    opc  = instr[31:26];
    fun  = instr[5:0];
    rt   = instr[20:16];
    rd   = instr[15:11];
    r_t  = !opc[5] && (opc[3:0] == 4'd0);
    j_t  = (opc[5:2] == 4'd0) && opc[1];
    i_t  = !(r_t || j_t);
    jal  = (opc == 6'd3);
    jr   = (opc == 6'd0) && (fun == 6'd8);
    jalr = (opc == 6'd0) && (fun == 6'd9);
    srl  = (opc == 6'd0) && (fun == 6'd2);
    ld   = (opc[5:3] == 3'b100);
    alu  = (r_t && (fun[5:4] == 2'b10)) || (i_t && (opc[5:3] == 3'b001));
    // Branch qualification looks at the rt field (REGIMM/blez/bgtz encodings), not fun.
    br   = (opc[5:3] == 3'b000) &&
           (((opc[2:0] == 3'b001) && (rt[4:1] == 4'd0)) ||
            (opc[2:1] == 2'b10) ||
            ((opc[2:1] == 2'b11) && (rt == 5'd0)));
    d             = '0;
    d.af          = r_t ? fun[3:0] : {!opc[2] && opc[1], opc[2:0]};
    d.i           = i_t;
    d.alu_mux_sel = r_t;
    d.cad         = jal ? 5'd31 : (r_t ? rd : rt);
    d.gp_we       = alu || srl || ld || jal || jalr;
    d.gp_mux_sel  = alu ? 2'd0 : (opc == 6'h23) ? 2'd1 : srl ? 2'd2 : 2'd3;
    d.bf          = {instr[28:26], instr[16]};
    d.dm_we       = (opc == 6'h2B);
    d.shift_type  = instr[2:0];
    d.pc_mux_sel  = (jr || jalr) ? 2'd0 : br ? 2'd1 : (j_t || jal) ? 2'd2 : 2'd3;
    d.is_load     = ld;
    return d;
  endfunction

  logic [31:0]     mem_instr_q [QDEPTH];
  logic [PC_W-1:0] mem_pc_q    [QDEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  dec_t            out_dec_q, out_dec_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [4:0]      out_rs_q, out_rs_d, out_rt_q, out_rt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] head_instr;
  logic        not_empty, push, pop, adv, hazard, issue, stall;

  assign head_instr = mem_instr_q[rd_ptr_q];
  assign not_empty  = (count_q != '0);
  assign in_ready   = (count_q != FULL) && !flush;
  assign push       = in_valid && in_ready;
  assign adv        = !out_valid_q || out_ready;
  assign hazard     = HZ_ON && out_valid_q && out_dec_q.is_load && (out_dec_q.cad != 5'd0) &&
                      ((out_dec_q.cad == head_instr[25:21]) || (out_dec_q.cad == head_instr[20:16]));
  assign issue      = adv && not_empty && !hazard && !flush;
  assign stall      = adv && not_empty && hazard && !flush;
  assign pop        = issue;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_dec_d   = out_dec_q;
    out_pc_d    = out_pc_q;
    out_rs_d    = out_rs_q;
    out_rt_d    = out_rt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (adv) begin
        out_valid_d = issue;
        if (issue) begin
          out_dec_d = decode(head_instr);
          out_pc_d  = mem_pc_q[rd_ptr_q];
          out_rs_d  = head_instr[25:21];
          out_rt_d  = head_instr[20:16];
        end
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
      out_pc_q    <= '0;
      out_rs_q    <= '0;
      out_rt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
      out_pc_q    <= out_pc_d;
      out_rs_q    <= out_rs_d;
      out_rt_q    <= out_rt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: the queue is only a few entries deep, so its storage is cleared on reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < QDEPTH; k++) begin
        mem_instr_q[k] <= '0;
        mem_pc_q[k]    <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_ptr_q] <= in_instr;
      mem_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_rs      = out_rs_q;
  assign out_rt      = out_rt_q;
  assign Af          = out_dec_q.af;
  assign I           = out_dec_q.i;
  assign ALU_MUX_SEL = out_dec_q.alu_mux_sel;
  assign Cad         = out_dec_q.cad;
  assign GP_WE       = out_dec_q.gp_we;
  assign GP_MUX_SEL  = out_dec_q.gp_mux_sel;
  assign Bf          = out_dec_q.bf;
  assign DM_WE       = out_dec_q.dm_we;
  assign Shift_type  = out_dec_q.shift_type;
  assign PC_MUX_SEL  = out_dec_q.pc_mux_sel;
  assign stall_cnt   = stall_cnt_q;

endmodule
